id_exe_reg: RTL and testbench

- Pipeline register between the ID stage (decoder/control unit, register file, sign extension) and the EXE stage of the 5-stage ARM core.
- Captures the control bundle (exeCMD, S_UpdateSig, branch, memReadEn, memWriteEn, writeBackEn) plus the operand/data fields.
- Supports freeze (global stall), flush (taken branch) and bubble (hazard) insertion.
- Keeps a saturating count of inserted bubbles for debug.

---
 rtl/id_exe_reg_pkg.sv | 24 ++
 rtl/id_exe_reg_field.sv | 22 ++
 rtl/id_exe_reg.sv | 96 +++++++++
 tb/tb_id_exe_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/id_exe_reg_pkg.sv
// id_exe_reg_pkg: EXE command encodings and the control bundle shared by the control unit, ID/EXE register and EXE stage.
package id_exe_reg_pkg;
    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       s;
        logic       b;
        logic       mr;
        logic       mw;
        logic       wb;
    } ctrl_t;
endpackage

// File: rtl/id_exe_reg_field.sv
// pipe_field_reg: width-parameterised pipeline register with async active-low reset, hold and synchronous clear.
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    // hold outranks clear so a stalled pipe never drops its instruction
    always_comb q_d = hold ? q_q : (clr ? '0 : d);

    always_ff @(posedge clk or negedge rst)
        if (!rst) q_q <= '0;
        else      q_q <= q_d;

    assign q = q_q;
endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with freeze, flush and bubble insertion plus a saturating bubble counter.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              bubble,
    input  logic [3:0]        exeCMD_in,
    input  logic              S_UpdateSig_in,
    input  logic              branch_in,
    input  logic              memReadEn_in,
    input  logic              memWriteEn_in,
    input  logic              writeBackEn_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] valRn_in,
    input  logic [DATA_W-1:0] valRm_in,
    input  logic              imm_in,
    input  logic [11:0]       shiftOperand_in,
    input  logic [23:0]       signedImm24_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    input  logic [3:0]        sr_in,
    output logic [3:0]        exeCMD,
    output logic              S_UpdateSig,
    output logic              branch,
    output logic              memReadEn,
    output logic              memWriteEn,
    output logic              writeBackEn,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] valRn,
    output logic [DATA_W-1:0] valRm,
    output logic              imm,
    output logic [11:0]       shiftOperand,
    output logic [23:0]       signedImm24,
    output logic [REG_W-1:0]  dest,
    output logic [REG_W-1:0]  src1,
    output logic [REG_W-1:0]  src2,
    output logic [3:0]        sr,
    output logic              valid,
    output logic [CNT_W-1:0]  bubbleCnt
);
    localparam int CW = $bits(ctrl_t) + 1;
    localparam int DW = 3 * DATA_W + 1 + 12 + 24 + 3 * REG_W + 4;

    ctrl_t          ctrl_in, ctrl_out;
    logic [CW-1:0]  ctrl_q;
    logic [DW-1:0]  data_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign ctrl_in = '{exe_cmd: exeCMD_in, s: S_UpdateSig_in, b: branch_in,
                       mr: memReadEn_in, mw: memWriteEn_in, wb: writeBackEn_in};

    // valid rides with the control bundle so it dies with the same kill
    pipe_field_reg #(.W(CW)) u_ctrl (
        .clk (clk),
        .rst (rst),
        .hold(freeze),
        .clr (flush | bubble),
        .d   ({ctrl_in, 1'b1}),
        .q   (ctrl_q)
    );

    pipe_field_reg #(.W(DW)) u_data (
        .clk (clk),
        .rst (rst),
        .hold(freeze),
        .clr (flush),
        .d   ({pc_in, valRn_in, valRm_in, imm_in, shiftOperand_in, signedImm24_in,
               dest_in, src1_in, src2_in, sr_in}),
        .q   (data_q)
    );

    assign {ctrl_out, valid} = ctrl_q;
    assign exeCMD      = ctrl_out.exe_cmd;
    assign S_UpdateSig = ctrl_out.s;
    assign branch      = ctrl_out.b;
    assign memReadEn   = ctrl_out.mr;
    assign memWriteEn  = ctrl_out.mw;
    assign writeBackEn = ctrl_out.wb;
    assign {pc, valRn, valRm, imm, shiftOperand, signedImm24, dest, src1, src2, sr} = data_q;

    always_comb cnt_d = (!freeze && (flush || bubble) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign bubbleCnt = cnt_q;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed checks of load, freeze, flush, bubble, priority, saturation and async reset.
module tb_id_exe_reg;
    import id_exe_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, bubble;
    logic [3:0]  exeCMD_in;
    logic        S_UpdateSig_in, branch_in, memReadEn_in, memWriteEn_in, writeBackEn_in;
    logic [31:0] pc_in, valRn_in, valRm_in;
    logic        imm_in;
    logic [11:0] shiftOperand_in;
    logic [23:0] signedImm24_in;
    logic [3:0]  dest_in, src1_in, src2_in, sr_in;
    logic [3:0]  exeCMD;
    logic        S_UpdateSig, branch, memReadEn, memWriteEn, writeBackEn;
    logic [31:0] pc, valRn, valRm;
    logic        imm;
    logic [11:0] shiftOperand;
    logic [23:0] signedImm24;
    logic [3:0]  dest, src1, src2, sr;
    logic        valid;
    logic [3:0]  bubbleCnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.DATA_W(32), .REG_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
        .exeCMD_in(exeCMD_in), .S_UpdateSig_in(S_UpdateSig_in), .branch_in(branch_in),
        .memReadEn_in(memReadEn_in), .memWriteEn_in(memWriteEn_in), .writeBackEn_in(writeBackEn_in),
        .pc_in(pc_in), .valRn_in(valRn_in), .valRm_in(valRm_in), .imm_in(imm_in),
        .shiftOperand_in(shiftOperand_in), .signedImm24_in(signedImm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .exeCMD(exeCMD), .S_UpdateSig(S_UpdateSig), .branch(branch), .memReadEn(memReadEn),
        .memWriteEn(memWriteEn), .writeBackEn(writeBackEn), .pc(pc), .valRn(valRn), .valRm(valRm),
        .imm(imm), .shiftOperand(shiftOperand), .signedImm24(signedImm24),
        .dest(dest), .src1(src1), .src2(src2), .sr(sr), .valid(valid), .bubbleCnt(bubbleCnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        {freeze, flush, bubble} = '0;
        exeCMD_in = '0;
        {S_UpdateSig_in, branch_in, memReadEn_in, memWriteEn_in, writeBackEn_in} = '0;
        {pc_in, valRn_in, valRm_in} = '0;
        imm_in = 1'b0; shiftOperand_in = '0; signedImm24_in = '0;
        {dest_in, src1_in, src2_in, sr_in} = '0;
    endtask

    // advance one rising edge and settle 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clr_in();
        exeCMD_in = 4'hF; {S_UpdateSig_in, branch_in, memReadEn_in, memWriteEn_in, writeBackEn_in} = '1;
        pc_in = 32'hDEAD_BEEF; valRn_in = 32'h1234; dest_in = 4'h7; sr_in = 4'hF;
        #12;
        chk("rst_exeCMD", exeCMD, 0);
        chk("rst_ctrl", {S_UpdateSig, branch, memReadEn, memWriteEn, writeBackEn}, 0);
        chk("rst_pc", pc, 0);
        chk("rst_data", {valRn, dest, sr}, 0);
        chk("rst_valid", valid, 0);
        chk("rst_cnt", bubbleCnt, 0);
        rst = 1'b1;

        clr_in(); exeCMD_in = EXE_ADD; writeBackEn_in = 1'b1; dest_in = 4'd3;
        step();
        chk("add_exeCMD", exeCMD, 4'b0010);
        chk("add_wb", writeBackEn, 1);
        chk("add_dest", dest, 3);
        chk("add_valid", valid, 1);

        clr_in(); exeCMD_in = EXE_ADD; memReadEn_in = 1'b1; writeBackEn_in = 1'b1; valRn_in = 32'h100;
        src1_in = 4'd2; shiftOperand_in = 12'hABC; imm_in = 1'b1;
        step();
        chk("ldr_mr", memReadEn, 1);
        chk("ldr_valRn", valRn, 32'h100);
        chk("ldr_shift", {imm, shiftOperand}, 13'h1ABC);

        for (int i = 0; i < 3; i++) begin
            freeze = 1'b1; flush = 1'b1; bubble = 1'b1;
            memReadEn_in = 1'b0; valRn_in = 32'h999 + i; pc_in = 32'h40 + i;
            step();
            chk("frz_mr", memReadEn, 1);
            chk("frz_valRn", valRn, 32'h100);
            chk("frz_valid", valid, 1);
            chk("frz_cnt", bubbleCnt, 0);
        end

        clr_in(); flush = 1'b1; bubble = 1'b1; memWriteEn_in = 1'b1; pc_in = 32'h20; valRn_in = 32'h77;
        step();
        chk("fl_mw", memWriteEn, 0);
        chk("fl_pc", pc, 0);
        chk("fl_valRn", valRn, 0);
        chk("fl_valid", valid, 0);
        chk("fl_cnt", bubbleCnt, 1);

        clr_in(); bubble = 1'b1; exeCMD_in = EXE_SUB; writeBackEn_in = 1'b1; valRm_in = 32'h55;
        memReadEn_in = 1'b1; branch_in = 1'b1; S_UpdateSig_in = 1'b1; memWriteEn_in = 1'b1; sr_in = 4'h6;
        step();
        chk("bb_exeCMD", exeCMD, 0);
        chk("bb_ctrl", {S_UpdateSig, branch, memReadEn, memWriteEn, writeBackEn}, 0);
        chk("bb_valid", valid, 0);
        chk("bb_valRm", valRm, 32'h55);
        chk("bb_sr", sr, 4'h6);
        chk("bb_cnt", bubbleCnt, 2);

        clr_in(); exeCMD_in = EXE_ADC; S_UpdateSig_in = 1'b1; branch_in = 1'b1; signedImm24_in = 24'hFFFFFE;
        src1_in = 4'd5; src2_in = 4'd9; sr_in = 4'hA; pc_in = 32'h44;
        step();
        chk("nrm_ctrl", {exeCMD, S_UpdateSig, branch, valid}, {4'b0011, 3'b111});
        chk("nrm_imm24", signedImm24, 24'hFFFFFE);
        chk("nrm_src", {src1, src2, sr}, 12'h59A);
        chk("nrm_pc", pc, 32'h44);
        chk("nrm_cnt", bubbleCnt, 2);

        clr_in(); bubble = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 12) chk("sat_reach", bubbleCnt, 15);
        end
        chk("sat_hold", bubbleCnt, 15);
        freeze = 1'b1;
        step();
        chk("sat_frz", bubbleCnt, 15);

        clr_in(); exeCMD_in = EXE_ORR; writeBackEn_in = 1'b1; valRn_in = 32'hCAFE;
        step();
        chk("pre_rst_valid", valid, 1);
        freeze = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_ctrl", {exeCMD, writeBackEn}, 0);
        chk("arst_valRn", valRn, 0);
        chk("arst_cnt", bubbleCnt, 0);
        step();
        rst = 1'b1; freeze = 1'b0; exeCMD_in = EXE_MVN;
        step();
        chk("post_rst_valid", valid, 1);
        chk("post_rst_cmd", exeCMD, 4'b1001);
        chk("post_rst_cnt", bubbleCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
